// File: rtl/calc_op_sequencer.sv
// calc_op_sequencer: top-level sequencer for the calculator datapath.
// Collects operand A, operator and operand B, launches the ALU with a delayed
// one-cycle start pulse, captures the result and chains it back as operand A.
// Optional build macro: CALC_SEQ_TIMEOUT_EN adds an ALU completion timeout.
// Without it the block waits in S_EXEC until alu_done, clr or rst.
module calc_op_sequencer #(
    parameter int WIDTH     = 40,
    parameter int START_DLY = 2,
    parameter int TIMEOUT   = 63
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             num_valid,
    input  logic [WIDTH-1:0] num_in,
    input  logic             op_valid,
    input  logic [1:0]       op_code,
    input  logic             eq_valid,
    input  logic             alu_done,
    input  logic [WIDTH-1:0] alu_res,
    input  logic             alu_err,
    output logic [1:0]       estado,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic [1:0]       op_sel,
    output logic             alu_start,
    output logic [WIDTH-1:0] result,
    output logic             res_valid,
    output logic             err
);

    typedef enum logic [1:0] {
        S_A    = 2'b00,
        S_OP   = 2'b01,
        S_B    = 2'b10,
        S_EXEC = 2'b11
    } state_t;

    localparam logic [3:0] DLY = 4'(START_DLY);

    // Parameter range guards, evaluated at elaboration only.
    generate
        if (START_DLY < 1 || START_DLY > 7) begin : g_bad_start_dly
            $error("START_DLY must be in 1..7");
        end
        if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
            $error("TIMEOUT must be in 1..255");
        end
    endgenerate

    state_t     state;
    logic       b_loaded;
    logic [2:0] dly_cnt;
    // waiting: start pulse has been issued, now looking for alu_done
    logic       waiting;
`ifdef CALC_SEQ_TIMEOUT_EN
    localparam logic [8:0] TMO = 9'(TIMEOUT);
    logic [7:0] tmo_cnt;
`endif

    assign estado = state;

    // Main sequencer: key handling with clr > eq > op > num priority, start
    // delay, result capture and (optionally) completion timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_A;
            op_a      <= '0;
            op_b      <= '0;
            op_sel    <= 2'b00;
            alu_start <= 1'b0;
            result    <= '0;
            res_valid <= 1'b0;
            err       <= 1'b0;
            b_loaded  <= 1'b0;
            dly_cnt   <= 3'd0;
            waiting   <= 1'b0;
`ifdef CALC_SEQ_TIMEOUT_EN
            tmo_cnt   <= 8'd0;
`endif
        end else if (clr) begin
            // Abort: clearing waiting means a late alu_done finds no window.
            state     <= S_A;
            op_a      <= '0;
            op_b      <= '0;
            op_sel    <= 2'b00;
            alu_start <= 1'b0;
            result    <= '0;
            res_valid <= 1'b0;
            err       <= 1'b0;
            b_loaded  <= 1'b0;
            dly_cnt   <= 3'd0;
            waiting   <= 1'b0;
`ifdef CALC_SEQ_TIMEOUT_EN
            tmo_cnt   <= 8'd0;
`endif
        end else begin
            alu_start <= 1'b0;
            res_valid <= 1'b0;
            case (state)
                S_A: begin
                    // A higher-priority eq/op key masks a simultaneous number.
                    if (!eq_valid && !op_valid && num_valid) begin
                        op_a  <= num_in;
                        err   <= 1'b0;
                        state <= S_OP;
                    end
                end
                S_OP: begin
                    if (eq_valid) begin
                        state <= S_OP;
                    end else if (op_valid) begin
                        op_sel <= op_code;
                        state  <= S_B;
                    end else if (num_valid) begin
                        op_a <= num_in;
                    end
                end
                S_B: begin
                    if (eq_valid) begin
                        if (b_loaded) begin
                            state   <= S_EXEC;
                            dly_cnt <= 3'd0;
                            waiting <= 1'b0;
                        end
                    end else if (op_valid) begin
                        op_sel <= op_code;
                    end else if (num_valid) begin
                        op_b     <= num_in;
                        b_loaded <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (!waiting) begin
                        dly_cnt <= dly_cnt + 3'd1;
                        if (({1'b0, dly_cnt} + 4'd1) == DLY) begin
                            alu_start <= 1'b1;
                            waiting   <= 1'b1;
`ifdef CALC_SEQ_TIMEOUT_EN
                            tmo_cnt   <= 8'd0;
`endif
                        end
                    end else if (!alu_start && alu_done) begin
                        // alu_done during the pulse cycle itself is ignored.
                        res_valid <= 1'b1;
                        b_loaded  <= 1'b0;
                        waiting   <= 1'b0;
                        dly_cnt   <= 3'd0;
                        if (alu_err) begin
                            result <= '0;
                            err    <= 1'b1;
                            state  <= S_A;
                        end else begin
                            result <= alu_res;
                            op_a   <= alu_res;
                            state  <= S_OP;
                        end
                    end
`ifdef CALC_SEQ_TIMEOUT_EN
                    else if (({1'b0, tmo_cnt} + 9'd1) == TMO) begin
                        err     <= 1'b1;
                        waiting <= 1'b0;
                        dly_cnt <= 3'd0;
                        state   <= S_A;
                    end else if (tmo_cnt != 8'hFF) begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
`endif
                end
                default: state <= S_A;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Self-checking bench for calc_op_sequencer: table of entry-phase vectors plus
// hand-written sequences for execution, chaining, errors, clr, timeout, reset.
module tb_calc_op_sequencer;

    localparam int W = 40;

    logic         clk = 1'b0;
    logic         rst, clr, num_valid, op_valid, eq_valid, alu_done, alu_err;
    logic [W-1:0] num_in, alu_res;
    logic [1:0]   op_code;
    logic [1:0]   estado, op_sel;
    logic [W-1:0] op_a, op_b, result;
    logic         alu_start, res_valid, err;

    int n_chk  = 0;
    int n_fail = 0;

    calc_op_sequencer #(.WIDTH(W), .START_DLY(2), .TIMEOUT(63)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .num_valid(num_valid), .num_in(num_in),
        .op_valid(op_valid), .op_code(op_code), .eq_valid(eq_valid),
        .alu_done(alu_done), .alu_res(alu_res), .alu_err(alu_err),
        .estado(estado), .op_a(op_a), .op_b(op_b), .op_sel(op_sel),
        .alu_start(alu_start), .result(result), .res_valid(res_valid), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         c, nv;
        logic [W-1:0] num;
        logic         ov;
        logic [1:0]   oc;
        logic         ev;
        logic [1:0]   e_st;
        logic [W-1:0] e_a, e_b;
        logic [1:0]   e_sel;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic key_num(input logic [W-1:0] v);
        num_valid = 1'b1; num_in = v; tick(); num_valid = 1'b0;
    endtask

    task automatic key_op(input logic [1:0] c);
        op_valid = 1'b1; op_code = c; tick(); op_valid = 1'b0;
    endtask

    task automatic key_eq();
        eq_valid = 1'b1; tick(); eq_valid = 1'b0;
    endtask

    // Bounded wait for the start pulse; returns with alu_start high if seen.
    task automatic wait_start(input string nm);
        int i;
        for (i = 0; i < 20 && !alu_start; i++) tick();
        chk({nm, "_start_seen"}, 64'(alu_start), 64'd1);
    endtask

    // Wait for start, let the pulse cycle pass, then return a result.
    task automatic run_alu(input string nm, input logic [W-1:0] r, input logic e);
        wait_start(nm);
        tick();
        alu_done = 1'b1; alu_res = r; alu_err = e;
        tick();
        alu_done = 1'b0; alu_err = 1'b0;
    endtask

    task automatic chk_out(input string nm, input logic [1:0] st, input logic [W-1:0] a,
                           input logic [W-1:0] r, input logic rv, input logic e);
        chk({nm, "_estado"}, 64'(estado), 64'(st));
        chk({nm, "_op_a"}, 64'(op_a), 64'(a));
        chk({nm, "_result"}, 64'(result), 64'(r));
        chk({nm, "_res_valid"}, 64'(res_valid), 64'(rv));
        chk({nm, "_err"}, 64'(err), 64'(e));
        $display("%s: estado=%0d op_a=%0d result=%0d res_valid=%0d err=%0d",
                 nm, estado, op_a, result, res_valid, err);
    endtask

    initial begin
        logic stuck;
        rst = 1'b1; clr = 1'b0; num_valid = 1'b0; op_valid = 1'b0; eq_valid = 1'b0;
        alu_done = 1'b0; alu_err = 1'b0; num_in = '0; alu_res = '0; op_code = 2'b00;

        //           clr   nv    num     ov    oc     ev    st     a       b       sel
        vecs[0]  = '{1'b0, 1'b1, 40'd5, 1'b0, 2'd0, 1'b0, 2'd1, 40'd5, 40'd0, 2'd0};
        vecs[1]  = '{1'b0, 1'b0, 40'd0, 1'b0, 2'd0, 1'b1, 2'd1, 40'd5, 40'd0, 2'd0};
        vecs[2]  = '{1'b0, 1'b1, 40'd6, 1'b0, 2'd0, 1'b0, 2'd1, 40'd6, 40'd0, 2'd0};
        vecs[3]  = '{1'b0, 1'b0, 40'd0, 1'b1, 2'd2, 1'b0, 2'd2, 40'd6, 40'd0, 2'd2};
        vecs[4]  = '{1'b0, 1'b0, 40'd0, 1'b0, 2'd0, 1'b1, 2'd2, 40'd6, 40'd0, 2'd2};
        vecs[5]  = '{1'b0, 1'b0, 40'd0, 1'b1, 2'd1, 1'b0, 2'd2, 40'd6, 40'd0, 2'd1};
        vecs[6]  = '{1'b0, 1'b1, 40'd7, 1'b0, 2'd0, 1'b0, 2'd2, 40'd6, 40'd7, 2'd1};
        vecs[7]  = '{1'b0, 1'b1, 40'd9, 1'b1, 2'd3, 1'b0, 2'd2, 40'd6, 40'd7, 2'd3};
        vecs[8]  = '{1'b1, 1'b0, 40'd0, 1'b0, 2'd0, 1'b1, 2'd0, 40'd0, 40'd0, 2'd0};
        vecs[9]  = '{1'b0, 1'b0, 40'd0, 1'b1, 2'd1, 1'b0, 2'd0, 40'd0, 40'd0, 2'd0};
        vecs[10] = '{1'b0, 1'b1, 40'd4, 1'b0, 2'd0, 1'b1, 2'd0, 40'd0, 40'd0, 2'd0};
        vecs[11] = '{1'b0, 1'b1, 40'd5, 1'b0, 2'd0, 1'b0, 2'd1, 40'd5, 40'd0, 2'd0};
        vecs[12] = '{1'b1, 1'b0, 40'd0, 1'b0, 2'd0, 1'b0, 2'd0, 40'd0, 40'd0, 2'd0};

        tick(); tick();
        rst = 1'b0;
        chk_out("reset", 2'd0, 40'd0, 40'd0, 1'b0, 1'b0);
        chk("reset_op_b", 64'(op_b), 64'd0);
        chk("reset_op_sel", 64'(op_sel), 64'd0);
        chk("reset_alu_start", 64'(alu_start), 64'd0);

        // Entry-phase vectors: one key event per cycle.
        for (int i = 0; i < 13; i++) begin
            clr = vecs[i].c; num_valid = vecs[i].nv; num_in = vecs[i].num;
            op_valid = vecs[i].ov; op_code = vecs[i].oc; eq_valid = vecs[i].ev;
            tick();
            clr = 1'b0; num_valid = 1'b0; op_valid = 1'b0; eq_valid = 1'b0;
            chk($sformatf("vec%0d_estado", i), 64'(estado), 64'(vecs[i].e_st));
            chk($sformatf("vec%0d_op_a", i), 64'(op_a), 64'(vecs[i].e_a));
            chk($sformatf("vec%0d_op_b", i), 64'(op_b), 64'(vecs[i].e_b));
            chk($sformatf("vec%0d_op_sel", i), 64'(op_sel), 64'(vecs[i].e_sel));
            chk($sformatf("vec%0d_alu_start", i), 64'(alu_start), 64'd0);
            $display("vec%0d: estado=%0d op_a=%0d op_b=%0d op_sel=%0d",
                     i, estado, op_a, op_b, op_sel);
        end

        // Basic add 5 + 7 with exact start timing; done during pulse is ignored.
        key_num(40'd5); key_op(2'd0); key_num(40'd7); key_eq();
        chk("add_estado_exec", 64'(estado), 64'd3);
        chk("add_start_e0", 64'(alu_start), 64'd0);
        tick();
        chk("add_start_e1", 64'(alu_start), 64'd0);
        tick();
        chk("add_start_e2", 64'(alu_start), 64'd1);
        alu_done = 1'b1; alu_res = 40'd99;
        tick();
        alu_done = 1'b0;
        chk("add_pulse_done_ignored", 64'(res_valid), 64'd0);
        chk("add_start_e3", 64'(alu_start), 64'd0);
        chk("add_still_exec", 64'(estado), 64'd3);
        tick();
        alu_done = 1'b1; alu_res = 40'd12;
        tick();
        alu_done = 1'b0;
        chk_out("add", 2'd1, 40'd12, 40'd12, 1'b1, 1'b0);
        tick();
        chk("add_res_valid_one_cycle", 64'(res_valid), 64'd0);

        // Chaining: 12 * 3.
        key_op(2'd2); key_num(40'd3); key_eq();
        run_alu("chain", 40'd36, 1'b0);
        chk_out("chain", 2'd1, 40'd36, 40'd36, 1'b1, 1'b0);

        // Error: 9 / 0, then a new number clears err.
        key_num(40'd9); key_op(2'd3); key_num(40'd0); key_eq();
        run_alu("div0", 40'd5, 1'b1);
        chk_out("div0", 2'd0, 40'd9, 40'd0, 1'b1, 1'b1);
        key_num(40'd2);
        chk_out("err_clear", 2'd1, 40'd2, 40'd0, 1'b0, 1'b0);

        // clr on the edge that would raise alu_start; late alu_done ignored.
        key_op(2'd0); key_num(40'd1); key_eq();
        tick();
        clr = 1'b1; tick(); clr = 1'b0;
        stuck = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (alu_start) stuck = 1'b1;
            tick();
        end
        chk("clr_no_start", 64'(stuck), 64'd0);
        alu_done = 1'b1; alu_res = 40'd77; tick(); alu_done = 1'b0;
        chk_out("clr_late_done", 2'd0, 40'd0, 40'd0, 1'b0, 1'b0);

        // Nonzero result so an unchanged result is observable later.
        key_num(40'd4); key_op(2'd0); key_num(40'd4); key_eq();
        run_alu("add8", 40'd8, 1'b0);
        chk_out("add8", 2'd1, 40'd8, 40'd8, 1'b1, 1'b0);

        // Missing alu_done.
        key_op(2'd0); key_num(40'd1); key_eq();
        wait_start("tmo");
`ifdef CALC_SEQ_TIMEOUT_EN
        for (int i = 0; i < 62; i++) tick();
        chk_out("tmo_before", 2'd3, 40'd8, 40'd8, 1'b0, 1'b0);
        tick();
        chk_out("tmo_fire", 2'd0, 40'd8, 40'd8, 1'b0, 1'b1);
`else
        stuck = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (estado != 2'd3) stuck = 1'b0;
        end
        chk("no_tmo_stays_exec", 64'(stuck), 64'd1);
        clr = 1'b1; tick(); clr = 1'b0;
        chk("no_tmo_clr_exit", 64'(estado), 64'd0);
        key_num(40'd8);
`endif

        // Async reset while the start pulse is high.
        key_op(2'd0); key_num(40'd3); key_eq();
        wait_start("rst");
        #2 rst = 1'b1;
        #1;
        chk_out("async_rst", 2'd0, 40'd0, 40'd0, 1'b0, 1'b0);
        chk("async_rst_op_b", 64'(op_b), 64'd0);
        chk("async_rst_op_sel", 64'(op_sel), 64'd0);
        chk("async_rst_alu_start", 64'(alu_start), 64'd0);
        tick();
        rst = 1'b0;
        key_num(40'd5);
        chk_out("post_rst_num", 2'd1, 40'd5, 40'd0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
